// File: rtl/cmp_pkg.sv
// Shared constants and types for the frame min/max tracker.
// The FSM state encoding lives here so the comparator and top agree on it.
package cmp_pkg;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    localparam int unsigned DEF_WIDTH     = 32;
    localparam int unsigned DEF_CNT_WIDTH = 16;

endpackage

// File: rtl/cmplt.sv
// Dual-mode strict less-than comparator: o_lt = (i_a < i_b).
// i_signed selects two's-complement (1) or unsigned (0) ordering.
module cmplt
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_signed,
    output logic             o_lt
);

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        w_a            = i_a;
        w_b            = i_b;
        w_a[WIDTH-1]   = i_a[WIDTH-1] ^ i_signed;
        w_b[WIDTH-1]   = i_b[WIDTH-1] ^ i_signed;
    end

    assign o_lt = (w_a < w_b);

endmodule

// File: rtl/cmp_minmax.sv
// Per-frame minimum/maximum tracker with earliest-occurrence indices.
// Accepts one sample per cycle in ACC, presents the frame result in OUT.
module cmp_minmax
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 is_signed,
    input  logic [CNT_WIDTH-1:0] frame_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_min,
    output logic [WIDTH-1:0]     out_max,
    output logic [CNT_WIDTH-1:0] out_min_idx,
    output logic [CNT_WIDTH-1:0] out_max_idx
);

    state_t               r_state;
    state_t               w_next_state;

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_last_idx;
    logic                 r_signed;
    logic [WIDTH-1:0]     r_min;
    logic [WIDTH-1:0]     r_max;
    logic [CNT_WIDTH-1:0] r_min_idx;
    logic [CNT_WIDTH-1:0] r_max_idx;

    logic                 w_accept;
    logic                 w_first;
    logic [CNT_WIDTH-1:0] w_last_idx;
    logic                 w_is_last;
    logic                 w_lt_min;
    logic                 w_gt_max;

    assign in_ready  = (r_state == ACC);
    assign out_valid = (r_state == OUT);
    assign w_accept  = in_valid && in_ready;
    assign w_first   = (r_cnt == '0);

    // On index 0 the live frame_len decides the end; afterwards the latched copy does.
    assign w_last_idx = w_first ? ((frame_len == '0) ? '0 : frame_len - CNT_WIDTH'(1))
                                : r_last_idx;
    assign w_is_last  = (r_cnt == w_last_idx);

    cmplt #(.WIDTH(WIDTH)) u_lt_min (
        .i_a      (in_data),
        .i_b      (r_min),
        .i_signed (r_signed),
        .o_lt     (w_lt_min)
    );

    cmplt #(.WIDTH(WIDTH)) u_gt_max (
        .i_a      (r_max),
        .i_b      (in_data),
        .i_signed (r_signed),
        .o_lt     (w_gt_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACC;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ACC: if (w_accept && w_is_last) w_next_state = OUT;
            OUT: if (out_ready)             w_next_state = ACC;
            default:                        w_next_state = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_last_idx <= '0;
            r_signed   <= 1'b0;
            r_min      <= '0;
            r_max      <= '0;
            r_min_idx  <= '0;
            r_max_idx  <= '0;
        end else if (w_accept) begin
            r_cnt <= w_is_last ? '0 : r_cnt + CNT_WIDTH'(1);
            if (w_first) begin
                r_signed   <= is_signed;
                r_last_idx <= w_last_idx;
                r_min      <= in_data;
                r_max      <= in_data;
                r_min_idx  <= '0;
                r_max_idx  <= '0;
            end else begin
                if (w_lt_min) begin
                    r_min     <= in_data;
                    r_min_idx <= r_cnt;
                end
                if (w_gt_max) begin
                    r_max     <= in_data;
                    r_max_idx <= r_cnt;
                end
            end
        end
    end

    // Running registers double as the result: nothing writes them while in OUT.
    assign out_min     = r_min;
    assign out_max     = r_max;
    assign out_min_idx = r_min_idx;
    assign out_max_idx = r_max_idx;

endmodule

// File: tb/tb_cmp_minmax.sv
// Scoreboard bench for cmp_minmax at WIDTH=8: expected frame results are
// queued as frames are driven and compared when out_valid is observed.
module tb_cmp_minmax;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 16;

    typedef struct packed {
        logic [W-1:0]  mn;
        logic [W-1:0]  mx;
        logic [CW-1:0] mni;
        logic [CW-1:0] mxi;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          is_signed;
    logic [CW-1:0] frame_len;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_min;
    logic [W-1:0]  out_max;
    logic [CW-1:0] out_min_idx;
    logic [CW-1:0] out_max_idx;

    res_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cmp_minmax #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .is_signed   (is_signed),
        .frame_len   (frame_len),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_min     (out_min),
        .out_max     (out_max),
        .out_min_idx (out_min_idx),
        .out_max_idx (out_max_idx)
    );

    function automatic bit less(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        if (s) return $signed(a) < $signed(b);
        return a < b;
    endfunction

    function automatic res_t model(input logic [W-1:0] d[$], input int n, input bit s);
        res_t r;
        r.mn = d[0]; r.mx = d[0]; r.mni = '0; r.mxi = '0;
        for (int i = 1; i < n; i++) begin
            if (less(d[i], r.mn, s)) begin r.mn = d[i]; r.mni = CW'(i); end
            if (less(r.mx, d[i], s)) begin r.mx = d[i]; r.mxi = CW'(i); end
        end
        return r;
    endfunction

    function automatic string fmt(input res_t r);
        return $sformatf("min=%h@%0d max=%h@%0d", r.mn, r.mni, r.mx, r.mxi);
    endfunction

    function automatic res_t cur();
        return {out_min, out_max, out_min_idx, out_max_idx};
    endfunction

    // Drives one frame (optionally with idle gaps / mid-frame control changes); queues the model result.
    task automatic send_frame(input logic [W-1:0] d[$], input logic [CW-1:0] len,
                              input bit sgn, input bit gaps, input bit chg);
        int n;
        n = (len == 0) ? 1 : int'(len);
        sb.push_back(model(d, n, sgn));
        frame_len = len;
        is_signed = sgn;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_data  = W'($urandom);
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = d[i];
            @(negedge clk);
            if (chg && i == 0) begin
                frame_len = 16'd2;
                is_signed = ~sgn;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic take_result(output bit ok, output res_t got);
        ok  = 1'b0;
        got = 'x;
        for (int i = 0; i < 20; i++) begin
            if (out_valid === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) begin
            got = cur();
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; is_signed = 1'b0; frame_len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || cur() !== '0) begin
            failures++;
            $display("FAIL reset_state got out_valid=%b %s exp out_valid=0 all zero", out_valid, fmt(cur()));
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
    endtask

    task automatic test_unsigned();
        logic [W-1:0] d[$];
        res_t e, got;
        bit ok;
        d = '{8'h10, 8'h80, 8'h05, 8'h7F};
        sb.push_back('{mn: 8'h05, mx: 8'h80, mni: 16'd2, mxi: 16'd1});
        frame_len = 16'd4; is_signed = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = d[i];
            @(negedge clk);
            checks++;
            if (out_valid !== (i == 3)) begin
                failures++;
                $display("FAIL unsigned_latency after sample %0d got out_valid=%b exp %b", i, out_valid, i == 3);
            end
        end
        in_valid = 1'b0;
        take_result(ok, got);
        e = sb.pop_front();
        checks++;
        if (!ok || got !== e) begin
            failures++;
            $display("FAIL unsigned_result got %s exp %s", fmt(got), fmt(e));
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL unsigned_release got out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_signed();
        res_t e, got;
        bit ok;
        send_frame('{8'h10, 8'h80, 8'h05, 8'h7F}, 16'd4, 1'b1, 1'b0, 1'b0);
        void'(sb.pop_front());
        sb.push_back('{mn: 8'h80, mx: 8'h7F, mni: 16'd1, mxi: 16'd3});
        take_result(ok, got);
        e = sb.pop_front();
        checks++;
        if (!ok || got !== e) begin
            failures++;
            $display("FAIL signed_result got %s exp %s", fmt(got), fmt(e));
        end
    endtask

    task automatic test_ties();
        res_t e, got;
        bit ok;
        send_frame('{8'h22, 8'h22, 8'h22}, 16'd3, 1'b0, 1'b0, 1'b0);
        take_result(ok, got);
        e = sb.pop_front();
        checks++;
        if (!ok || got !== e || got.mni !== 16'd0 || got.mxi !== 16'd0) begin
            failures++;
            $display("FAIL ties_result got %s exp %s", fmt(got), fmt(e));
        end
        send_frame('{8'h9C}, 16'd0, 1'b1, 1'b0, 1'b0);
        take_result(ok, got);
        e = sb.pop_front();
        checks++;
        if (!ok || got !== '{mn: 8'h9C, mx: 8'h9C, mni: 16'd0, mxi: 16'd0} || got !== e) begin
            failures++;
            $display("FAIL len0_result got %s exp %s", fmt(got), fmt(e));
        end
    endtask

    task automatic test_backpressure();
        res_t e, got;
        bit ok;
        send_frame('{8'h33, 8'hF0, 8'h01, 8'h44, 8'h01}, 16'd5, 1'b1, 1'b0, 1'b0);
        e = sb.pop_front();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_data = W'($urandom);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || cur() !== e) begin
                failures++;
                $display("FAIL backpressure_hold cycle %0d got v=%b r=%b %s exp v=1 r=0 %s",
                         c, out_valid, in_ready, fmt(cur()), fmt(e));
            end
        end
        in_valid = 1'b0;
        take_result(ok, got);
        checks++;
        if (!ok || got !== e) begin
            failures++;
            $display("FAIL backpressure_result got %s exp %s", fmt(got), fmt(e));
        end
    endtask

    task automatic test_gaps();
        logic [W-1:0] d[$];
        res_t e, got;
        bit ok;
        for (int rep = 0; rep < 3; rep++) begin
            d = {};
            for (int i = 0; i < 6; i++) d.push_back(W'($urandom));
            send_frame(d, 16'd6, rep[0], 1'b1, 1'b0);
            take_result(ok, got);
            e = sb.pop_front();
            checks++;
            if (!ok || got !== e) begin
                failures++;
                $display("FAIL gaps_result rep %0d got %s exp %s", rep, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_midframe_change();
        res_t e, got;
        bit ok;
        send_frame('{8'h10, 8'h80, 8'h05, 8'h7F}, 16'd4, 1'b0, 1'b0, 1'b1);
        take_result(ok, got);
        e = sb.pop_front();
        checks++;
        if (!ok || got !== e) begin
            failures++;
            $display("FAIL midframe_change_result got %s exp %s", fmt(got), fmt(e));
        end
        send_frame('{8'hFF, 8'h00, 8'h80, 8'h7F, 8'h00}, 16'd5, 1'b1, 1'b0, 1'b1);
        take_result(ok, got);
        e = sb.pop_front();
        checks++;
        if (!ok || got !== e) begin
            failures++;
            $display("FAIL midframe_change_signed got %s exp %s", fmt(got), fmt(e));
        end
    endtask

    task automatic test_reset_midframe();
        res_t e, got;
        bit ok;
        frame_len = 16'd4; is_signed = 1'b0;
        in_valid = 1'b1; in_data = 8'hA5; @(negedge clk);
        in_data = 8'h5A; @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || cur() !== '0) begin
            failures++;
            $display("FAIL reset_midframe_clear got v=%b %s exp v=0 all zero", out_valid, fmt(cur()));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame('{8'h07, 8'h03, 8'h09, 8'h03}, 16'd4, 1'b0, 1'b0, 1'b0);
        take_result(ok, got);
        e = sb.pop_front();
        checks++;
        if (!ok || got !== e) begin
            failures++;
            $display("FAIL reset_midframe_fresh got %s exp %s", fmt(got), fmt(e));
        end
        send_frame('{8'h11, 8'h22}, 16'd2, 1'b0, 1'b0, 1'b0);
        void'(sb.pop_front());
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || cur() !== '0) begin
            failures++;
            $display("FAIL reset_in_out got v=%b %s exp v=0 all zero", out_valid, fmt(cur()));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d[$];
        logic [CW-1:0] len;
        res_t e, got;
        bit ok;
        for (int f = 0; f < 8; f++) begin
            d = {};
            len = CW'($urandom_range(1, 6));
            for (int i = 0; i < int'(len); i++) d.push_back(W'($urandom_range(0, 3) * 8'h41));
            send_frame(d, len, f[1], 1'b0, 1'b0);
            take_result(ok, got);
            e = sb.pop_front();
            checks++;
            if (!ok || got !== e) begin
                failures++;
                $display("FAIL back_to_back frame %0d got %s exp %s", f, fmt(got), fmt(e));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_ties();
        test_backpressure();
        test_gaps();
        test_midframe_change();
        test_reset_midframe();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmp_minmax.md
CMP_MINMAX -- requirements
Module: cmp_minmax

Interface
REQ-001 Parameter WIDTH, default 32, sample width in bits; legal minimum 2.
REQ-002 Parameter CNT_WIDTH, default 16, width of frame length and index fields.
REQ-003 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1, reset: asynchronous assert, active-low.
REQ-005 Port is_signed, input, 1: 1 = two's-complement compare, 0 = unsigned compare.
REQ-006 Port frame_len, input, CNT_WIDTH, number of samples per frame.
REQ-007 Port in_valid, input, 1, sample present.
REQ-008 Port in_ready, output, 1, block accepts sample.
REQ-009 Port in_data, input, WIDTH, sample value.
REQ-010 Port out_valid, output, 1, frame result present.
REQ-011 Port out_ready, input, 1, consumer accepts result.
REQ-012 Port out_min / out_max, output, WIDTH each, frame minimum / maximum.
REQ-013 Port out_min_idx / out_max_idx, output, CNT_WIDTH each, zero-based position in frame of out_min / out_max.

Function
REQ-014 A sample is accepted in any cycle where in_valid and in_ready are both 1; a result is taken in any cycle where out_valid and out_ready are both 1.
REQ-015 FSM states ACC and OUT; in_ready = (state == ACC); out_valid = (state == OUT); no other outputs depend combinationally on inputs.
REQ-016 frame_len and is_signed are sampled on the first accepted sample of a frame and held until the frame completes; changes mid-frame are ignored.
REQ-017 frame_len == 0 is treated as 1.
REQ-018 First sample of a frame (index 0) loads both running min and max, with both indices set to 0.
REQ-019 Each later sample x at index k replaces min only if x < min, and replaces max only if max < x; the index is updated to k together with the value.
REQ-020 Ties therefore keep the earliest occurrence for both min and max.
REQ-021 Comparison is a strict less-than with sign mode per REQ-016, over the full WIDTH bits.
REQ-022 Sample counter increments per accepted sample and clears when the frame completes; no wrap is possible because frame_len <= 2^CNT_WIDTH-1.
REQ-023 Acceptance of the sample with index (effective frame_len - 1) moves ACC -> OUT; out_min, out_max, and both indices are registered with that sample included.
REQ-024 out_valid rises the cycle after the last sample is accepted (latency 1).
REQ-025 In OUT, all result outputs are held stable until taken; taking the result moves OUT -> ACC in the same edge.
REQ-026 in_ready is 0 throughout OUT (no overlap); maximum throughput is one frame per (frame_len + 1) cycles.
REQ-027 Idle cycles (in_valid = 0) in ACC change nothing.

Reset
REQ-028 rst_n = 0 forces state ACC, counter 0, out_valid 0, in_ready 1 (after release), and out_min, out_max, out_min_idx, out_max_idx to 0.
REQ-029 Reset mid-frame or mid-OUT discards partial and pending results; the first sample accepted after release is index 0.

Structure
REQ-030 State encodings (ACC = 1'b0, OUT = 1'b1) are shared constants in package cmp_pkg.
REQ-031 Two instances of the existing signed/unsigned dual-mode comparator sub-module cmplt (WIDTH passed through) are used.
REQ-032 One cmplt instance computes x < min and the other computes max < x; both are driven by the latched sign mode, except on index 0, where REQ-018 applies.

Verification (WIDTH=8)
REQ-033 Unsigned mode: frame_len=4, data 10,80,05,7F -> min 05 at idx 2, max 80 at idx 1; out_valid rises 1 cycle after the 4th sample.
REQ-034 Signed mode: same data -> min 80 (-128) at idx 1, max 7F at idx 3.
REQ-035 Ties: frame_len=3, data 22,22,22 -> min = max = 22, both indices 0. Separately, frame_len=0 with data 9C -> single-sample frame, min = max = 9C, both indices 0.
REQ-036 Backpressure and gaps:
- out_ready held 0 for 5 cycles -> outputs stable and in_ready 0 throughout.
- in_valid toggling during ACC -> same result as contiguous input.
- frame_len and is_signed changed mid-frame -> no effect on the current frame.
REQ-037 Reset after 2 of 4 samples -> out_valid 0 and all outputs 0; the next 4 samples form a fresh frame with correct result.
